// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical memory port between the I-cache
// and D-cache line-fill/writeback ports, one line transaction at a time.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> ties go to the client that was not granted last (last_grant reg)
//   undefined -> fixed priority, D-cache wins ties
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   icache_pmem_read/addr         I-cache line read request (held until resp)
//   icache_pmem_rdata/resp        line and 1-cycle completion pulse to I-cache
//   dcache_pmem_read/write/addr   D-cache read / writeback request (held until resp)
//   dcache_pmem_wdata             writeback line
//   dcache_pmem_rdata/resp        line and 1-cycle completion pulse to D-cache
//   mem_read/write/addr/wdata     physical memory request, driven from latched regs
//   mem_rdata/resp                physical memory read line and completion pulse
module cache_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_addr,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_addr,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              is_write_q;
    logic              grant_i;
    logic              grant_d;
    logic              i_req;
    logic              d_req;
    logic              d_wins_tie;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the D-cache received the most recent grant
    logic last_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d <= 1'b1;
        end else if (grant_i | grant_d) begin
            last_grant_d <= grant_d;
        end
    end

    assign d_wins_tie = ~last_grant_d;
`else
    assign d_wins_tie = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch; mem_* is driven only from these during a transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else if (grant_d) begin
            addr_q     <= dcache_pmem_addr;
            wdata_q    <= dcache_pmem_wdata;
            is_write_q <= dcache_pmem_write;
        end else if (grant_i) begin
            addr_q     <= icache_pmem_addr;
            is_write_q <= 1'b0;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next state, grant decode, memory strobes and client responses
    always_comb begin
        state_nxt         = state;
        grant_i           = 1'b0;
        grant_d           = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        icache_pmem_resp  = 1'b0;
        dcache_pmem_resp  = 1'b0;
        icache_pmem_rdata = '0;
        dcache_pmem_rdata = '0;
        case (state)
            IDLE: begin
                // mem_resp here is stray and deliberately ignored
                if (d_req && (!i_req || d_wins_tie)) begin
                    grant_d   = 1'b1;
                    state_nxt = D_BUSY;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    icache_pmem_resp  = 1'b1;
                    icache_pmem_rdata = mem_rdata;
                    state_nxt         = IDLE;
                end
            end
            D_BUSY: begin
                mem_write = is_write_q;
                mem_read  = ~is_write_q;
                if (mem_resp) begin
                    dcache_pmem_resp  = 1'b1;
                    dcache_pmem_rdata = mem_rdata;
                    state_nxt         = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: self-checking bench for cache_arbiter. A transaction-level
// model decides which client each grant belongs to and what the memory port
// must show; a simple memory responder completes each transaction.
module tb_cache_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_addr;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_addr;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_pmem_read  (icache_pmem_read),
        .icache_pmem_addr  (icache_pmem_addr),
        .icache_pmem_rdata (icache_pmem_rdata),
        .icache_pmem_resp  (icache_pmem_resp),
        .dcache_pmem_read  (dcache_pmem_read),
        .dcache_pmem_write (dcache_pmem_write),
        .dcache_pmem_addr  (dcache_pmem_addr),
        .dcache_pmem_wdata (dcache_pmem_wdata),
        .dcache_pmem_rdata (dcache_pmem_rdata),
        .dcache_pmem_resp  (dcache_pmem_resp),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_resp          (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: 1 when the D-cache was granted most recently (reset value D)
    logic model_last_d;

    // Observations of one transaction gathered by serve()
    logic              obs_found;
    int                obs_waits;
    logic              obs_rd;
    logic              obs_wr;
    logic [ADDR_W-1:0] obs_addr;
    logic [LINE_W-1:0] obs_wdata;
    logic              obs_stable;
    logic              obs_iresp;
    logic              obs_dresp;
    logic [LINE_W-1:0] obs_irdata;
    logic [LINE_W-1:0] obs_drdata;
    logic              obs_idle;
    logic              scramble_d;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Arbitration rule: returns 1 when the D-cache gets the next grant
    function automatic logic model_pick_d(input logic ireq, input logic dreq);
        if (!ireq) return dreq;
        if (!dreq) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        return !model_last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive_idle();
        icache_pmem_read  = 1'b0;
        icache_pmem_addr  = '0;
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
        dcache_pmem_addr  = '0;
        dcache_pmem_wdata = '0;
        mem_resp          = 1'b0;
        mem_rdata         = '0;
    endtask

    // Memory responder: wait (bounded) for a strobe, hold lat cycles, pulse
    // mem_resp with rd, then drop the served client's request.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rd);
        obs_found  = 1'b0;
        obs_waits  = 0;
        obs_stable = 1'b1;
        obs_iresp  = 1'b0;
        obs_dresp  = 1'b0;
        obs_idle   = 1'b0;
        while (!obs_found && obs_waits < 20) begin
            @(negedge clk); #1;
            obs_waits++;
            if (mem_read || mem_write) obs_found = 1'b1;
        end
        if (!obs_found) return;
        obs_rd    = mem_read;
        obs_wr    = mem_write;
        obs_addr  = mem_addr;
        obs_wdata = mem_wdata;
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            if (scramble_d) begin
                dcache_pmem_addr  = $urandom;
                dcache_pmem_wdata = rand_line();
            end
            #1;
            if (mem_read !== obs_rd || mem_write !== obs_wr || mem_addr !== obs_addr ||
                mem_wdata !== obs_wdata || icache_pmem_resp || dcache_pmem_resp)
                obs_stable = 1'b0;
        end
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = rd;
        #1;
        if (mem_read !== obs_rd || mem_write !== obs_wr || mem_addr !== obs_addr) obs_stable = 1'b0;
        obs_iresp  = icache_pmem_resp;
        obs_dresp  = dcache_pmem_resp;
        obs_irdata = icache_pmem_rdata;
        obs_drdata = dcache_pmem_rdata;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = rand_line();
        if (obs_iresp) icache_pmem_read = 1'b0;
        if (obs_dresp) begin
            dcache_pmem_read  = 1'b0;
            dcache_pmem_write = 1'b0;
        end
        #1;
        obs_idle = !mem_read && !mem_write;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        icache_pmem_read = 1'b1;
        dcache_pmem_write = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({mem_read, mem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {mem_read, mem_write, icache_pmem_resp, dcache_pmem_resp});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || icache_pmem_rdata !== '0 || dcache_pmem_rdata !== '0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        drive_idle();
        rst = 1'b0;
        model_last_d = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        logic [LINE_W-1:0] rd;
        rd = rand_line();
        @(negedge clk);
        icache_pmem_read = 1'b1;
        icache_pmem_addr = 32'h0000_1000;
        serve(5, rd);
        model_last_d = 1'b0;
        checks++;
        if (!obs_found || obs_waits != 1) begin
            failures++;
            $display("FAIL i_read_latency: got found=%0b waits=%0d expected 1/1", obs_found, obs_waits);
        end
        checks++;
        if ({obs_rd, obs_wr} !== 2'b10 || obs_addr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL i_read_req: got rd=%b wr=%b addr=%h expected 1 0 00001000", obs_rd, obs_wr, obs_addr);
        end
        checks++;
        if ({obs_iresp, obs_dresp} !== 2'b10 || obs_irdata !== rd) begin
            failures++;
            $display("FAIL i_read_resp: got iresp=%b dresp=%b rdata=%h expected 1 0 %h",
                     obs_iresp, obs_dresp, obs_irdata, rd);
        end
        checks++;
        if (!obs_stable || !obs_idle) begin
            failures++;
            $display("FAIL i_read_hold: got stable=%b idle=%b expected 1 1", obs_stable, obs_idle);
        end
    endtask

    task automatic test_d_write();
        logic [LINE_W-1:0] wd;
        wd = {8{32'hA5A5_A5A5}};
        @(negedge clk);
        dcache_pmem_write = 1'b1;
        dcache_pmem_addr  = 32'h0000_2000;
        dcache_pmem_wdata = wd;
        serve(4, rand_line());
        model_last_d = 1'b1;
        checks++;
        if (!obs_found || {obs_rd, obs_wr} !== 2'b01 || obs_addr !== 32'h0000_2000 || obs_wdata !== wd) begin
            failures++;
            $display("FAIL d_write_req: got rd=%b wr=%b addr=%h wdata=%h expected 0 1 00002000 %h",
                     obs_rd, obs_wr, obs_addr, obs_wdata, wd);
        end
        checks++;
        if ({obs_iresp, obs_dresp} !== 2'b01 || !obs_stable || !obs_idle) begin
            failures++;
            $display("FAIL d_write_resp: got iresp=%b dresp=%b stable=%b idle=%b expected 0 1 1 1",
                     obs_iresp, obs_dresp, obs_stable, obs_idle);
        end
    endtask

    task automatic test_addr_change();
        @(negedge clk);
        dcache_pmem_read = 1'b1;
        dcache_pmem_addr = 32'h0000_3000;
        scramble_d = 1'b1;
        serve(6, rand_line());
        scramble_d = 1'b0;
        model_last_d = 1'b1;
        checks++;
        if (!obs_found || obs_addr !== 32'h0000_3000 || !obs_stable || obs_dresp !== 1'b1) begin
            failures++;
            $display("FAIL addr_change: got addr=%h stable=%b dresp=%b expected 00003000 1 1",
                     obs_addr, obs_stable, obs_dresp);
        end
    endtask

    // Simultaneous I and D reads, repeated twice to exercise the tie rule
    task automatic test_tie();
        logic first_d;
        logic [LINE_W-1:0] rd;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            icache_pmem_read = 1'b1;
            icache_pmem_addr = 32'h0000_5000;
            dcache_pmem_read = 1'b1;
            dcache_pmem_addr = 32'h0000_6000;
            first_d = model_pick_d(1'b1, 1'b1);
            for (int j = 0; j < 2; j++) begin
                logic exp_d;
                exp_d = (j == 0) ? first_d : !first_d;
                rd = rand_line();
                serve(3, rd);
                model_last_d = exp_d;
                checks++;
                if (!obs_found || obs_waits != 1 || obs_addr !== (exp_d ? 32'h0000_6000 : 32'h0000_5000) ||
                    {obs_iresp, obs_dresp} !== {!exp_d, exp_d} || !obs_idle) begin
                    failures++;
                    $display("FAIL tie_order[%0d.%0d]: got addr=%h waits=%0d iresp=%b dresp=%b idle=%b expected d=%b",
                             r, j, obs_addr, obs_waits, obs_iresp, obs_dresp, obs_idle, exp_d);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [LINE_W-1:0] rd;
        rd = rand_line();
        @(negedge clk);
        icache_pmem_read = 1'b1;
        icache_pmem_addr = 32'h0000_7000;
        @(negedge clk); #1;
        checks++;
        if (mem_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_grant: got mem_read=%b expected 1", mem_read);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0 || icache_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_drop: got mem_read=%b iresp=%b expected 0 0", mem_read, icache_pmem_resp);
        end
        mem_resp = 1'b1;
        #1;
        checks++;
        if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_noresp: got iresp=%b dresp=%b expected 0 0", icache_pmem_resp, dcache_pmem_resp);
        end
        @(negedge clk);
        mem_resp = 1'b0;
        rst = 1'b0;
        model_last_d = 1'b1;
        serve(3, rd);
        model_last_d = 1'b0;
        checks++;
        if (!obs_found || obs_waits != 1 || obs_addr !== 32'h0000_7000 || obs_iresp !== 1'b1 || obs_irdata !== rd) begin
            failures++;
            $display("FAIL mid_reset_regrant: got waits=%0d addr=%h iresp=%b expected 1 00007000 1",
                     obs_waits, obs_addr, obs_iresp);
        end
    endtask

    task automatic test_stray_resp();
        drive_idle();
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = rand_line();
        #1;
        checks++;
        if ({icache_pmem_resp, dcache_pmem_resp, mem_read, mem_write} !== 4'b0) begin
            failures++;
            $display("FAIL stray_resp: got %b expected 0000",
                     {icache_pmem_resp, dcache_pmem_resp, mem_read, mem_write});
        end
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b0) begin
            failures++;
            $display("FAIL stray_resp_idle: got %b expected 00", {mem_read, mem_write});
        end
    endtask

    // Random request mixes checked against the transaction model
    task automatic test_random();
        int                pat;
        int                dop;
        logic              ireq;
        logic              dreq;
        logic              dwr;
        logic              first_d;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] da;
        logic [LINE_W-1:0] dw;
        logic [LINE_W-1:0] rd;
        for (int n = 0; n < 30; n++) begin
            pat  = $urandom_range(0, 2);
            dop  = $urandom_range(0, 2);
            ireq = (pat != 1);
            dreq = (pat != 0);
            dwr  = (dop != 0);
            ia   = $urandom;
            da   = $urandom;
            dw   = rand_line();
            @(negedge clk);
            icache_pmem_read  = ireq;
            icache_pmem_addr  = ia;
            dcache_pmem_read  = dreq && (dop != 1);
            dcache_pmem_write = dreq && dwr;
            dcache_pmem_addr  = da;
            dcache_pmem_wdata = dw;
            first_d = model_pick_d(ireq, dreq);
            for (int j = 0; j < ((ireq && dreq) ? 2 : 1); j++) begin
                logic exp_d;
                exp_d = (j == 0) ? first_d : !first_d;
                rd = rand_line();
                serve($urandom_range(1, 6), rd);
                model_last_d = exp_d;
                checks++;
                if (!obs_found || obs_waits != 1) begin
                    failures++;
                    $display("FAIL rand_grant[%0d.%0d]: got found=%b waits=%0d expected 1 1", n, j, obs_found, obs_waits);
                end
                checks++;
                if (obs_addr !== (exp_d ? da : ia) || obs_rd !== !(exp_d && dwr) || obs_wr !== (exp_d && dwr) ||
                    (exp_d && dwr && obs_wdata !== dw)) begin
                    failures++;
                    $display("FAIL rand_req[%0d.%0d]: got addr=%h rd=%b wr=%b expected addr=%h wr=%b",
                             n, j, obs_addr, obs_rd, obs_wr, exp_d ? da : ia, exp_d && dwr);
                end
                checks++;
                if ({obs_iresp, obs_dresp} !== {!exp_d, exp_d} || (exp_d ? obs_drdata : obs_irdata) !== rd ||
                    !obs_stable || !obs_idle) begin
                    failures++;
                    $display("FAIL rand_resp[%0d.%0d]: got iresp=%b dresp=%b stable=%b idle=%b expected d=%b",
                             n, j, obs_iresp, obs_dresp, obs_stable, obs_idle, exp_d);
                end
            end
        end
    endtask

    initial begin
        scramble_d   = 1'b0;
        model_last_d = 1'b1;
        test_reset();
        test_i_read();
        test_d_write();
        test_addr_change();
        test_tie();
        test_reset_mid();
        test_stray_resp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
